// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional perf counters in inst_fetch are enabled by INST_FETCH_PERF_EN.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t;

  localparam logic [8:0] HALT_WORD = 9'b1111_11_111;

  localparam int unsigned DEF_IW = 10;
  localparam int unsigned DEF_DW = 9;
  localparam int unsigned DEF_CW = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, one-entry IR, start/halt sequencing, branch flush, stall hold.
// Define INST_FETCH_PERF_EN to add StallCount/FlushCount outputs.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned IW = DEF_IW,
  parameter int unsigned DW = DEF_DW,
  parameter int unsigned CW = DEF_CW
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [IW-1:0] StartAddr,
  input  logic [DW-1:0] InstIn,
  input  logic          Stall,
  input  logic          BranchTaken,
  input  logic [IW-1:0] BranchTarget,
  output logic [IW-1:0] InstAddress,
  output logic [DW-1:0] Inst,
  output logic [IW-1:0] InstPC,
  output logic          InstValid,
  output logic          Busy,
  output logic          Done,
`ifdef INST_FETCH_PERF_EN
  output logic [CW-1:0] StallCount,
  output logic [CW-1:0] FlushCount,
`endif
  output logic [CW-1:0] CycleCount
);

  fetch_state_t  state_q, state_d;
  logic [IW-1:0] pc_q, pc_d;
  logic [DW-1:0] inst_q, inst_d;
  logic [IW-1:0] ipc_q, ipc_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  logic running;
  logic start_go;
  logic ir_halt;

  assign running  = (state_q == RUN);
  assign start_go = Start && !running;
  assign ir_halt  = valid_q && (inst_q == DW'(HALT_WORD));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    done_d  = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = StartAddr;
          valid_d = 1'b0;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        // Branch beats halt and stall: the word fetched behind it is dropped.
        if (BranchTaken) begin
          pc_d    = BranchTarget;
          valid_d = 1'b0;
        end else if (ir_halt && !Stall) begin
          state_d = DONE;
          done_d  = 1'b1;
          valid_d = 1'b0;
        end else if (!Stall) begin
          inst_d  = InstIn;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      inst_q  <= '0;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign InstAddress = pc_q;
  assign Inst        = inst_q;
  assign InstPC      = ipc_q;
  assign InstValid   = valid_q;
  assign Busy        = running;
  assign Done        = done_q;

  sat_counter #(.W(CW)) u_cycle_cnt (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (start_go),
    .inc   (running),
    .count (CycleCount)
  );

`ifdef INST_FETCH_PERF_EN
  sat_counter #(.W(CW)) u_stall_cnt (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (start_go),
    .inc   (running && Stall && !BranchTaken),
    .count (StallCount)
  );

  sat_counter #(.W(CW)) u_flush_cnt (
    .clk   (Clk),
    .rst_n (Reset_n),
    .clr   (start_go),
    .inc   (running && BranchTaken),
    .count (FlushCount)
  );
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: per-cycle vector table plus wrap and reset sequences.
module tb_inst_fetch;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       Start;
  logic [9:0] StartAddr;
  logic [8:0] InstIn;
  logic       Stall;
  logic       BranchTaken;
  logic [9:0] BranchTarget;
  logic [9:0] InstAddress;
  logic [8:0] Inst;
  logic [9:0] InstPC;
  logic       InstValid;
  logic       Busy;
  logic       Done;
  logic [15:0] CycleCount;
`ifdef INST_FETCH_PERF_EN
  logic [15:0] StallCount;
  logic [15:0] FlushCount;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  localparam logic [8:0] HALT = 9'h1FF;

  inst_fetch #(.IW(10), .DW(9), .CW(16)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Start        (Start),
    .StartAddr    (StartAddr),
    .InstIn       (InstIn),
    .Stall        (Stall),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .InstAddress  (InstAddress),
    .Inst         (Inst),
    .InstPC       (InstPC),
    .InstValid    (InstValid),
    .Busy         (Busy),
    .Done         (Done),
`ifdef INST_FETCH_PERF_EN
    .StallCount   (StallCount),
    .FlushCount   (FlushCount),
`endif
    .CycleCount   (CycleCount)
  );

  always #5 Clk = ~Clk;

  // ROM image: halt words at 3, 5, 10, 24; everything else is a non-halt word.
  function automatic logic [8:0] rom_word(input logic [9:0] a);
    if (a == 10'd3 || a == 10'd5 || a == 10'd10 || a == 10'd24) return HALT;
    return {1'b0, a[7:0]};
  endfunction

  always_comb InstIn = rom_word(InstAddress);

  typedef struct {
    logic        start;
    logic [9:0]  saddr;
    logic        stall;
    logic        br;
    logic [9:0]  btgt;
    logic [9:0]  e_addr;
    logic        e_valid;
    logic [9:0]  e_ipc;
    logic        e_busy;
    logic        e_done;
    logic [15:0] e_cyc;
    logic [15:0] e_stall;
    logic [15:0] e_flush;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(input logic st, input int sa, input logic sl, input logic b,
                              input int bt, input int ad, input logic v, input int ip,
                              input logic bs, input logic dn, input int cy, input int sc,
                              input int fc);
    vec_t r;
    r.start = st; r.saddr = 10'(sa); r.stall = sl; r.br = b; r.btgt = 10'(bt);
    r.e_addr = 10'(ad); r.e_valid = v; r.e_ipc = 10'(ip); r.e_busy = bs; r.e_done = dn;
    r.e_cyc = 16'(cy); r.e_stall = 16'(sc); r.e_flush = 16'(fc);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic [9:0] sa, input logic sl,
                       input logic b, input logic [9:0] bt);
    Start = st; StartAddr = sa; Stall = sl; BranchTaken = b; BranchTarget = bt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // start, saddr, stall, br, btgt | addr, valid, ipc, busy, done, cyc, stallcnt, flushcnt
    // program A: 0..2 then halt at 3
    vecs[0]  = mk(1, 0, 0, 0, 0,    0, 0, 0,  1, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0,    1, 1, 0,  1, 0, 1, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0,    2, 1, 1,  1, 0, 2, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0,    3, 1, 2,  1, 0, 3, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0,    4, 1, 3,  1, 0, 4, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0,    4, 0, 3,  0, 1, 5, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0,    4, 0, 3,  0, 1, 5, 0, 0);
    // program B: branch at 4 -> 20, halt word at 5 flushed, halt at 24
    vecs[7]  = mk(1, 4, 0, 0, 0,    4, 0, 3,  1, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0,    5, 1, 4,  1, 0, 1, 0, 0);
    vecs[9]  = mk(0, 0, 0, 1, 20,  20, 0, 4,  1, 0, 2, 0, 1);
    vecs[10] = mk(0, 0, 0, 0, 0,   21, 1, 20, 1, 0, 3, 0, 1);
    vecs[11] = mk(0, 0, 0, 0, 0,   22, 1, 21, 1, 0, 4, 0, 1);
    vecs[12] = mk(0, 0, 0, 0, 0,   23, 1, 22, 1, 0, 5, 0, 1);
    vecs[13] = mk(0, 0, 0, 0, 0,   24, 1, 23, 1, 0, 6, 0, 1);
    vecs[14] = mk(0, 0, 0, 0, 0,   25, 1, 24, 1, 0, 7, 0, 1);
    vecs[15] = mk(0, 0, 0, 0, 0,   25, 0, 24, 0, 1, 8, 0, 1);
    // program C: 3-cycle stall at 7, branch overriding stall, ignored Start, stalled halt
    vecs[16] = mk(1, 6, 0, 0, 0,    6, 0, 24, 1, 0, 0, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0,    7, 1, 6,  1, 0, 1, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 0,    8, 1, 7,  1, 0, 2, 0, 0);
    vecs[19] = mk(0, 0, 1, 0, 0,    8, 1, 7,  1, 0, 3, 1, 0);
    vecs[20] = mk(0, 0, 1, 0, 0,    8, 1, 7,  1, 0, 4, 2, 0);
    vecs[21] = mk(0, 0, 1, 0, 0,    8, 1, 7,  1, 0, 5, 3, 0);
    vecs[22] = mk(0, 0, 0, 0, 0,    9, 1, 8,  1, 0, 6, 3, 0);
    vecs[23] = mk(0, 0, 1, 1, 9,    9, 0, 8,  1, 0, 7, 3, 1);
    vecs[24] = mk(1, 100, 0, 0, 0, 10, 1, 9,  1, 0, 8, 3, 1);
    vecs[25] = mk(0, 0, 0, 0, 0,   11, 1, 10, 1, 0, 9, 3, 1);
    vecs[26] = mk(0, 0, 1, 0, 0,   11, 1, 10, 1, 0, 10, 4, 1);
    vecs[27] = mk(0, 0, 0, 0, 0,   11, 0, 10, 0, 1, 11, 4, 1);

    Reset_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    repeat (3) tick();
    Reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("idle%0d addr", i), 32'(InstAddress), 0);
      chk($sformatf("idle%0d valid", i), 32'(InstValid), 0);
      chk($sformatf("idle%0d busy", i), 32'(Busy), 0);
      chk($sformatf("idle%0d done", i), 32'(Done), 0);
    end
    chk("idle cyc", 32'(CycleCount), 0);

    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].start, vecs[i].saddr, vecs[i].stall, vecs[i].br, vecs[i].btgt);
      tick();
      chk($sformatf("v%0d addr", i), 32'(InstAddress), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d valid", i), 32'(InstValid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d ipc", i), 32'(InstPC), 32'(vecs[i].e_ipc));
      chk($sformatf("v%0d busy", i), 32'(Busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d done", i), 32'(Done), 32'(vecs[i].e_done));
      chk($sformatf("v%0d cyc", i), 32'(CycleCount), 32'(vecs[i].e_cyc));
      if (vecs[i].e_valid)
        chk($sformatf("v%0d inst", i), 32'(Inst), 32'(rom_word(vecs[i].e_ipc)));
`ifdef INST_FETCH_PERF_EN
      chk($sformatf("v%0d stallcnt", i), 32'(StallCount), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d flushcnt", i), 32'(FlushCount), 32'(vecs[i].e_flush));
`endif
    end
    drive(0, 0, 0, 0, 0);

    // PC wrap: 1023 -> 0, then 1, 2, halt at 3
    drive(1, 10'd1023, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("wrap start addr", 32'(InstAddress), 1023);
    tick();
    chk("wrap ipc0", 32'(InstPC), 1023);
    chk("wrap addr0", 32'(InstAddress), 0);
    tick();
    chk("wrap ipc1", 32'(InstPC), 0);
    chk("wrap inst1", 32'(Inst), 0);
    begin
      int n = 0;
      while (!Done && n < 20) begin
        tick();
        n++;
      end
      chk("wrap done reached", 32'(Done), 1);
    end
    chk("wrap cyc", 32'(CycleCount), 6);
    chk("wrap last ipc", 32'(InstPC), 3);

    // asynchronous reset in the middle of a run
    drive(1, 10'd50, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    chk("pre-rst ipc", 32'(InstPC), 51);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("rst addr", 32'(InstAddress), 0);
    chk("rst inst", 32'(Inst), 0);
    chk("rst ipc", 32'(InstPC), 0);
    chk("rst valid", 32'(InstValid), 0);
    chk("rst busy", 32'(Busy), 0);
    chk("rst done", 32'(Done), 0);
    chk("rst cyc", 32'(CycleCount), 0);
    tick();
    Reset_n = 1'b1;
    tick();
    chk("post-rst idle busy", 32'(Busy), 0);
    drive(1, 10'd50, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    chk("rerun addr", 32'(InstAddress), 50);
    chk("rerun valid0", 32'(InstValid), 0);
    tick();
    chk("rerun ipc50", 32'(InstPC), 50);
    chk("rerun inst50", 32'(Inst), 32'(rom_word(10'd50)));
    tick();
    chk("rerun ipc51", 32'(InstPC), 51);
    chk("rerun cyc", 32'(CycleCount), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Fetch stage that drives the instruction ROM's address input and registers its combinational output into a one-entry instruction register (IR) for decode/execute.
- Owns the program counter (PC), start/halt sequencing, taken-branch redirect with IR flush, and stall hold.
- Sits between the top-level controller (`Start`/`Done`) and the instruction ROM; the decoder consumes `Inst`/`InstValid`.

Parameters:
- `IW`, 10, PC / instruction-address width (ROM depth 2**IW).
- `DW`, 9, machine-code width.
- `CW`, 16, cycle-counter width.

Ports:
- `Clk`  in  1  single clock, rising edge.
- `Reset_n`  in  1  reset, asynchronous, active-low.
- `Start`  in  1  one-cycle pulse; begins a program at `StartAddr`.
- `StartAddr`  in  IW  entry address sampled with `Start`.
- `InstIn`  in  DW  ROM read data for `InstAddress` (same cycle).
- `Stall`  in  1  hold PC and IR this cycle.
- `BranchTaken`  in  1  instruction in IR is a taken branch.
- `BranchTarget`  in  IW  absolute redirect address.
- `InstAddress`  out  IW  PC, to ROM.
- `Inst`  out  DW  IR contents.
- `InstPC`  out  IW  address the IR word was fetched from.
- `InstValid`  out  1  IR holds a live instruction.
- `Busy`  out  1  state == RUN.
- `Done`  out  1  program halted; held until next `Start`.
- `CycleCount`  out  CW  cycles spent in RUN, saturating.

Behaviour:
- Reset (async, `Reset_n`=0): state IDLE; PC=0; `Inst`=0; `InstPC`=0; `InstValid`=0; `Busy`=0; `Done`=0; `CycleCount`=0. Reset mid-run aborts immediately.
- States: IDLE, RUN, DONE. Outputs are registered; `InstAddress` is the PC register.
- IDLE/DONE + `Start`:
  - next state RUN; PC<=`StartAddr`; `InstValid`<=0; `CycleCount`<=0; `Done`<=0.
  - First valid `Inst` appears 1 cycle after entering RUN.
- RUN, `Start`: ignored.
- RUN, per cycle, priority order:
  1. `BranchTaken`: PC<=`BranchTarget`; `InstValid`<=0 (the sequentially fetched word is flushed). Overrides `Stall`.
  2. IR halt (`InstValid`=1 and `Inst`==`HALT_WORD`) with `Stall`=0: state<=DONE; `Done`<=1; `InstValid`<=0; PC held.
  3. `Stall`: PC, IR, `InstPC`, `InstValid` all hold.
  4. Otherwise: `Inst`<=`InstIn`; `InstPC`<=PC; `InstValid`<=1; PC<=PC+1.
- PC increment wraps modulo 2**IW (2**IW-1 -> 0); no error is flagged.
- Halt is recognised only in IR, so a halt word fetched behind a taken branch is flushed and never executes.
- `CycleCount` increments on every RUN cycle, including stalled and final-halt cycles, and saturates at 2**CW-1. It holds in IDLE/DONE.
- `Busy`=1 exactly when the state is RUN.

Optional Feature:
- Macro `INST_FETCH_PERF_EN`.
- Defined:
  - Adds output ports `StallCount` (CW) and `FlushCount` (CW).
  - `StallCount` counts RUN cycles with `Stall`=1 and `BranchTaken`=0.
  - `FlushCount` counts RUN cycles with `BranchTaken`=1.
  - Both clear on `Start` and on reset, and saturate at 2**CW-1.
- Undefined: those ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package `fetch_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t`.
  - `localparam HALT_WORD = 9'b1111_11_111`.
  - Default widths `IW`, `DW`, `CW`.
- Sub-module `sat_counter` (parameter `W`; inputs `clr`, `inc`; saturating).
  - One instance for `CycleCount`; two more under `INST_FETCH_PERF_EN`.

Test Plan:
- Reset release, no `Start` -> `InstAddress`=0, `InstValid`=0, `Busy`=0, `Done`=0 for 20 cycles.
- `Start` with `StartAddr`=0, ROM words 0..2 non-halt, word 3 = `HALT_WORD`:
  - `InstPC` sequence 0,1,2,3, then `Done`=1 and `Busy`=0.
  - `CycleCount`=5.
- Taken branch at `InstPC`=4 with `BranchTarget`=20:
  - next cycle `InstValid`=0 and `InstAddress`=20.
  - following cycle `InstPC`=20.
  - address 5's word (set to `HALT_WORD`) is never executed.
- `Stall` held 3 cycles at `InstPC`=7 -> `Inst`/`InstPC`/`InstAddress` frozen. With `INST_FETCH_PERF_EN`, `StallCount`=3.
- `StartAddr`=1023, IW=10 -> PC wraps to 0 after fetching 1023; `InstPC` sequence 1023, 0.
- Assert `Reset_n`=0 mid-RUN, then `Start` again -> all outputs reset asynchronously; program re-executes from `StartAddr`.
